// File: rtl/edge_seq_pkg.sv
// Shared types and constants for the edge-sequence generator.
// Holds the FSM state encoding, the default segment-length width and the
// segment command layout used by the generator and its prefetch buffer.
package edge_seq_pkg;

    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Segment command at the default length width.
    typedef struct packed {
        logic                     level;
        logic [LEN_W_DEFAULT-1:0] len;
    } seg_cmd_t;

    function automatic seg_cmd_t make_seg_cmd(input logic level,
                                              input logic [LEN_W_DEFAULT-1:0] len);
        seg_cmd_t c;
        c.level = level;
        c.len   = len;
        return c;
    endfunction

endpackage

// File: rtl/edge_seq_cmd_buf.sv
// One-entry valid/data holding register for a prefetched segment command.
// A push and a pop on the same edge leave the entry valid with new data.
module edge_seq_cmd_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Valid flag: set on push (push wins over a same-edge pop), cleared on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (push_i) begin
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload register.
    // NOTE: payload is not reset; it is only ever read while valid_q is set.
    always_ff @(posedge clk) begin
        if (push_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/edge_seq_gen.sv
// Edge-sequence generator: drives line_o through back-to-back segments of
// {level, len+1 cycles} with registered rise/fall markers on each transition.
// Optional feature macro: EDGE_SEQ_GEN_PREFETCH_EN adds a one-entry command
// prefetch buffer so the next command can be accepted mid-segment.
module edge_seq_gen
    import edge_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_level,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             line_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             seg_done_o,
    output logic             busy_o
);

    // Same layout as seg_cmd_t, sized by this instance's LEN_W.
    typedef struct packed {
        logic             level;
        logic [LEN_W-1:0] len;
    } cmd_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             line_q, line_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic seg_last;
    logic load_slot;
    logic accept;
    logic load;
    logic buf_valid;
    cmd_t in_cmd;
    cmd_t load_cmd;

    assign in_cmd.level = cmd_level;
    assign in_cmd.len   = cmd_len;

    assign seg_last  = (state_q == DRIVE) && (cnt_q == '0);
    assign load_slot = (state_q == IDLE) || seg_last;

`ifdef EDGE_SEQ_GEN_PREFETCH_EN
    cmd_t buf_cmd;
    logic buf_push;
    logic buf_pop;

    assign cmd_ready = !rst && !buf_valid;
    assign accept    = cmd_valid && cmd_ready;
    // The buffered command is older, so it loads first; otherwise bypass.
    assign load      = load_slot && (buf_valid || accept);
    assign load_cmd  = buf_valid ? buf_cmd : in_cmd;
    assign buf_pop   = load && buf_valid;
    // An accepted command is stored unless it bypasses straight into the line.
    assign buf_push  = accept && !(load && !buf_valid);

    edge_seq_cmd_buf #(
        .W($bits(cmd_t))
    ) u_cmd_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (buf_push),
        .pop_i  (buf_pop),
        .data_i (in_cmd),
        .valid_o(buf_valid),
        .data_o (buf_cmd)
    );
`else
    assign buf_valid = 1'b0;
    assign cmd_ready = !rst && ((state_q == IDLE) || (cnt_q == '0));
    assign accept    = cmd_valid && cmd_ready;
    assign load      = accept;
    assign load_cmd  = in_cmd;
`endif

    // Next-state: load a segment, finish to IDLE, or count down the current one.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (load) begin
            state_d = DRIVE;
            cnt_d   = load_cmd.len;
            line_d  = load_cmd.level;
            rise_d  = ~line_q & load_cmd.level;
            fall_d  = line_q & ~load_cmd.level;
        end else if (seg_last) begin
            state_d = IDLE;
        end else if (state_q == DRIVE) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    // State registers with synchronous reset dominating all other inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign line_o     = line_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign seg_done_o = seg_last;
    assign busy_o     = (state_q == DRIVE) || buf_valid;

endmodule

// File: doc/edge_seq_gen.md
# edge_seq_gen

Edge-sequence generator: the drive side of the rise/fall edge detector. It accepts a stream of segment commands, each a level and a hold length, and drives a single-bit line through those levels back-to-back with no gap cycles. It also emits registered rise and fall markers that coincide with each line transition. It sits upstream of the edge detector as a stimulus and pattern source, for example for handshake or strobe waveforms.

## Interface
Parameters:
- LEN_W, 8: width of the segment length field. A segment lasts cmd_len+1 cycles, from 1 to 2^LEN_W cycles.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a segment command is presented.
- cmd_ready  out  1  the block accepts the command this cycle.
- cmd_level  in  1  line level for the segment.
- cmd_len  in  LEN_W  segment duration minus 1.
- line_o  out  1  generated line, registered.
- rise_o  out  1  high for the one cycle in which line_o has just gone 0->1. Registered.
- fall_o  out  1  high for the one cycle in which line_o has just gone 1->0. Registered.
- seg_done_o  out  1  high during the final cycle of each segment.
- busy_o  out  1  a segment is being driven, or a command is buffered.

## Operation
- FSM states:
  - IDLE: no segment active.
  - DRIVE: a segment is active; cnt counts down from cmd_len to 0.
- A command is accepted on any rising edge where cmd_valid && cmd_ready.
- Load event, on an edge when state is IDLE, or DRIVE with cnt==0, and a command is available:
  - line_o <= level
  - cnt <= len
  - state <= DRIVE
  - rise_o <= ~line_o & level
  - fall_o <= line_o & ~level
- No load in the final cycle of a segment: state <= IDLE. line_o holds its last level indefinitely and rise_o/fall_o go 0.
- Rise/fall markers assert for exactly one cycle, in the first cycle of a segment. Only one of the two may be high in any cycle.
- Consecutive segments at the same level produce no marker. The line stays flat, and the two durations add.
- seg_done_o = (state==DRIVE) && (cnt==0). This is combinational from registered state.
- busy_o = (state==DRIVE) || buf_valid. buf_valid is always 0 when EDGE_SEQ_GEN_PREFETCH_EN is not defined.
- cmd_len = all-ones: the segment lasts 2^LEN_W cycles. The counter must not wrap early.
- Reset: rst dominates every other input and is sampled on an edge. After that edge:
  - line_o=0, rise_o=0, fall_o=0
  - cnt=0, state=IDLE, buf_valid=0
  - seg_done_o=0, busy_o=0
- Reset mid-segment: the segment and any buffered command are discarded. cmd_ready is forced to 0 while rst=1.

## Timing
- Latency: for a command loaded at edge t, line_o and its marker take the new values in the cycle following t.
- The segment occupies cycles t+1 .. t+1+cmd_len, and seg_done_o is high in the last of these.
- Zero-gap chaining: a command available in the final cycle of a segment loads at that edge. The next segment starts the following cycle, with no idle cycle.
- Once IDLE is reached, cmd_ready stays high until a load occurs.

## Configuration
- Macro: EDGE_SEQ_GEN_PREFETCH_EN.
- Undefined:
  - No buffer.
  - cmd_ready = !rst && (state==IDLE || cnt==0), which is combinational.
  - Commands load directly from the input port.
- Defined: a one-entry prefetch buffer.
  - cmd_ready = !rst && !buf_valid.
  - At a load event, the buffer has priority if it is valid. Otherwise an accepted input command bypasses the buffer and loads directly.
  - A command accepted while no load event occurs is written to the buffer, and buf_valid <= 1.
  - A simultaneous load from the buffer and acceptance of a new command on the same edge is legal: the new command refills the buffer.
  - Load latency is identical in both builds.

## Structure
- Package edge_seq_pkg holds:
  - the state enum (IDLE, DRIVE);
  - the default LEN_W constant;
  - the packed struct seg_cmd_t {level, len}.
- Sub-module edge_seq_cmd_buf: the one-entry valid/data holding register. It is instantiated only under EDGE_SEQ_GEN_PREFETCH_EN.

## Test plan
- Reset: hold rst 2 cycles. Required after that:
  - line_o=0, rise_o=0, fall_o=0, seg_done_o=0, busy_o=0.
  - cmd_ready=0 during rst, then 1 the cycle after rst deasserts.
- Single segment: {level=1, len=3} accepted at edge t. Required:
  - line_o=1 for cycles t+1..t+4, with rise_o in t+1 only.
  - seg_done_o in t+4.
  - busy_o=0 and line_o still 1 in t+5.
- Chaining: {1,2} then {0,0} with cmd_valid held high. Required:
  - line_o 1,1,1 then 0.
  - fall_o in the first 0 cycle.
  - No idle cycle between the segments.
- Same-level merge: {1,1},{1,1}. Required: line_o high for 4 consecutive cycles, exactly one rise_o, and two seg_done_o pulses.
- Reset mid-segment: {1,200} with rst asserted at cycle 10 of the segment. Required: line_o=0 and busy_o=0 after that edge, and no seg_done_o.
- Prefetch (macro defined): {0,5} is loaded, then a second command is accepted in the segment's first cycle. Required:
  - cmd_ready=0 until the buffer drains.
  - The second segment starts exactly one cycle after seg_done_o.
- Length extreme: LEN_W=4 with cmd_len=15. Required: the segment lasts 16 cycles.
